count_enable_ctrl: RTL and testbench

Upstream control stage for the modulus counters: turns three raw push-buttons (start, stop, single-step) into the `enable` qualifier that the counter samples. The block synchronises and debounces the buttons and runs a small run/step state machine. While running, a prescaler emits a one-cycle `enable` pulse every DIV clocks. Its `enable` output connects directly to the counter's `enable` input on the same `clk`/`reset_n` domain.

---
 rtl/count_enable_ctrl.sv | 99 +++++++++
 tb/tb_count_enable_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/count_enable_ctrl.sv
// rtl/count_enable_ctrl.sv - button sync/debounce, run/step FSM and prescaled enable pulse
module count_enable_ctrl #(
  parameter int DIV      = 10,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       step_btn,
  output logic       enable,
  output logic       running,
  output logic [1:0] state
);

  localparam int PW = $clog2(DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE - 1);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_STEP = 2'b10;

  // Button index: 0 = stop, 1 = start, 2 = step
  logic [2:0]    w_raw;
  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    r_deb;
  logic [2:0]    r_deb_d;
  logic [CW-1:0] r_cnt [3];
  logic [2:0]    w_press;

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic [PW-1:0] r_pre;

  assign w_raw   = {step_btn, start_btn, stop_btn};
  assign w_press = r_deb & ~r_deb_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      // A level is accepted only after DEBOUNCE consecutive differing samples
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] != r_deb[i]) begin
          if (r_cnt[i] == DEB_MAX) begin
            r_deb[i] <= r_sync2[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // Priority stop > start > step; a stop press in IDLE also masks start/step
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_press[0])      w_next = ST_IDLE;
        else if (w_press[1]) w_next = ST_RUN;
        else if (w_press[2]) w_next = ST_STEP;
      end
      ST_RUN:  if (w_press[0]) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_pre   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_RUN && w_next == ST_RUN)
        r_pre <= (r_pre == PRE_MAX) ? '0 : r_pre + 1'b1;
      else
        r_pre <= '0;
    end
  end

  assign enable  = (r_state == ST_RUN && r_pre == PRE_MAX) || (r_state == ST_STEP);
  assign running = (r_state == ST_RUN);
  assign state   = r_state;

endmodule

// File: tb/tb_count_enable_ctrl.sv
// tb/tb_count_enable_ctrl.sv - directed and random checks of count_enable_ctrl against a behavioural model
module tb_count_enable_ctrl;

  localparam int DIV = 4;
  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start_btn = 1'b0;
  logic       stop_btn = 1'b0;
  logic       step_btn = 1'b0;
  logic       enable;
  logic       running;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  count_enable_ctrl #(.DIV(DIV), .DEBOUNCE(DEB)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start_btn (start_btn),
    .stop_btn  (stop_btn),
    .step_btn  (step_btn),
    .enable    (enable),
    .running   (running),
    .state     (state)
  );

  always #5 clk = ~clk;

  // Model: button bit 0 = stop, 1 = start, 2 = step; mode 0 idle, 1 run, 2 step
  bit [2:0]  m_s1, m_s2, m_deb, m_press;
  bit [31:0] m_hist [3];
  int        m_since [3];
  int        m_mode;
  int        m_edge;
  int        m_run_start;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit [2:0]  raw;
    bit [2:0]  deb_old;
    bit [31:0] mask;
    bit        exp_en;
    raw  = {step_btn, start_btn, stop_btn};
    mask = (32'd1 << DEB) - 32'd1;
    @(posedge clk);
    m_edge++;
    if (!reset_n) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_press = '0; m_mode = 0;
      for (int i = 0; i < 3; i++) begin m_hist[i] = '0; m_since[i] = 0; end
    end else begin
      case (m_mode)
        0: begin
          if (m_press[0]) m_mode = 0;
          else if (m_press[1]) begin m_mode = 1; m_run_start = m_edge; end
          else if (m_press[2]) m_mode = 2;
        end
        1: if (m_press[0]) m_mode = 0;
        default: m_mode = 0;
      endcase
      deb_old = m_deb;
      for (int i = 0; i < 3; i++) begin
        m_hist[i] = {m_hist[i][30:0], m_s2[i]};
        m_since[i]++;
        if (m_since[i] >= DEB && (m_hist[i] & mask) == (m_deb[i] ? 32'd0 : mask)) begin
          m_deb[i]   = ~m_deb[i];
          m_since[i] = 0;
        end
      end
      m_press = m_deb & ~deb_old;
      m_s2 = m_s1;
      m_s1 = raw;
    end
    exp_en = (m_mode == 1 && ((m_edge - m_run_start) % DIV) == DIV - 1) || (m_mode == 2);
    #1;
    check("model_state", {30'b0, state}, m_mode);
    check("model_running", {31'b0, running}, {31'b0, m_mode == 1});
    check("model_enable", {31'b0, enable}, {31'b0, exp_en});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press_stop();
    stop_btn = 1'b1; ticks(8);
    stop_btn = 1'b0; ticks(8);
    check("stop_idle", {30'b0, state}, 32'd0);
  endtask

  initial begin
    int  pulses;
    bit  saw_step;
    bit  found;
    int  k;

    // Reset with all buttons held
    reset_n = 1'b0; start_btn = 1'b1; stop_btn = 1'b1; step_btn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_enable", {31'b0, enable}, 32'd0);
      check("rst_running", {31'b0, running}, 32'd0);
      check("rst_state", {30'b0, state}, 32'd0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < DEB + 1; i++) begin
      tick();
      check("post_rst_state", {30'b0, state}, 32'd0);
      check("post_rst_enable", {31'b0, enable}, 32'd0);
    end
    start_btn = 1'b0; stop_btn = 1'b0; step_btn = 1'b0;
    ticks(10);

    // Run: start held 10 clocks
    start_btn = 1'b1;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (e == 9) start_btn = 1'b0;
      if (e == 5) check("run_state_e5", {30'b0, state}, 32'd0);
      if (e == 6) check("run_state_e6", {30'b0, state}, 32'd1);
      check("run_enable_edge", {31'b0, enable}, {31'b0, (e == 9 || e == 13 || e == 17)});
    end
    press_stop();

    // Single step held 50 clocks
    pulses = 0; saw_step = 1'b0;
    step_btn = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (enable) pulses++;
      if (state == 2'b10) saw_step = 1'b1;
    end
    step_btn = 1'b0;
    ticks(8);
    check("step_pulses", pulses, 32'd1);
    check("step_seen", {31'b0, saw_step}, 32'd1);
    check("step_back_idle", {30'b0, state}, 32'd0);

    // Glitch rejection
    start_btn = 1'b1; ticks(3);
    start_btn = 1'b0; ticks(10);
    check("glitch3_idle", {30'b0, state}, 32'd0);
    start_btn = 1'b1; ticks(4);
    start_btn = 1'b0; ticks(8);
    check("pulse4_run", {30'b0, state}, 32'd1);
    press_stop();

    // Simultaneous presses
    stop_btn = 1'b1; start_btn = 1'b1; ticks(8);
    stop_btn = 1'b0; start_btn = 1'b0; ticks(8);
    check("stop_start_idle", {30'b0, state}, 32'd0);
    saw_step = 1'b0;
    start_btn = 1'b1; step_btn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (state == 2'b10) saw_step = 1'b1;
    end
    start_btn = 1'b0; step_btn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (state == 2'b10) saw_step = 1'b1;
    end
    check("start_step_run", {30'b0, state}, 32'd1);
    check("start_step_nostep", {31'b0, saw_step}, 32'd0);
    press_stop();

    // Reset mid-RUN at prescaler 2, then fresh start
    start_btn = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (m_mode == 1 && ((m_edge - m_run_start) % DIV) == 2) found = 1'b1;
    end
    check("mid_run_reached", {31'b0, found}, 32'd1);
    start_btn = 1'b0;
    reset_n = 1'b0; tick();
    reset_n = 1'b1;
    check("mid_rst_state", {30'b0, state}, 32'd0);
    check("mid_rst_enable", {31'b0, enable}, 32'd0);
    ticks(6);
    start_btn = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (running) found = 1'b1;
    end
    check("restart_run", {31'b0, found}, 32'd1);
    start_btn = 1'b0;
    k = 0; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      k++;
      if (enable) found = 1'b1;
    end
    check("restart_first_en_seen", {31'b0, found}, 32'd1);
    check("restart_first_en_lat", k, DIV - 1);
    press_stop();

    // Random button activity with occasional reset
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) start_btn = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) stop_btn  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) step_btn  = 1'($urandom_range(0, 1));
      reset_n = ($urandom_range(0, 149) != 0);
      tick();
    end
    reset_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
